// File: rtl/cpu_pkg.sv
// Shared pipeline-control types: hazard FSM states, register index width
// and the bundle of stall/flush strobes driven by the hazard controller.
package cpu_pkg;

  localparam int REG_IDX_W = 4;
  localparam logic [REG_IDX_W-1:0] ZERO_REG = 4'd0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALTED   = 2'd2
  } hz_state_t;

  typedef struct packed {
    logic stall_pc;
    logic stall_if_id;
    logic stall_id_ex;
    logic stall_ex_mem;
    logic stall_mem_wb;
    logic flush_if_id;
    logic flush_id_ex;
    logic flush_ex_mem;
    logic flush_mem_wb;
  } hz_ctl_t;

  // Freeze everything up to MEM and retire a bubble from WB.
  localparam hz_ctl_t HZ_GROUP_A = '{
    stall_pc: 1'b1, stall_if_id: 1'b1, stall_id_ex: 1'b1, stall_ex_mem: 1'b1,
    stall_mem_wb: 1'b0, flush_if_id: 1'b0, flush_id_ex: 1'b0,
    flush_ex_mem: 1'b0, flush_mem_wb: 1'b1};

  // Squash the two younger instructions fetched down the wrong path.
  localparam hz_ctl_t HZ_REDIRECT = '{
    stall_pc: 1'b0, stall_if_id: 1'b0, stall_id_ex: 1'b0, stall_ex_mem: 1'b0,
    stall_mem_wb: 1'b0, flush_if_id: 1'b1, flush_id_ex: 1'b1,
    flush_ex_mem: 1'b0, flush_mem_wb: 1'b0};

  // Hold the consumer in ID and push a bubble behind the load.
  localparam hz_ctl_t HZ_LOAD_USE = '{
    stall_pc: 1'b1, stall_if_id: 1'b1, stall_id_ex: 1'b0, stall_ex_mem: 1'b0,
    stall_mem_wb: 1'b0, flush_if_id: 1'b0, flush_id_ex: 1'b1,
    flush_ex_mem: 1'b0, flush_mem_wb: 1'b0};

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle. The pipeline (master) reports stage
// state; the controller (slave) returns stall/flush strobes and status.
interface hazard_ctrl_if;
  import cpu_pkg::*;

  logic [REG_IDX_W-1:0] id_rs1;
  logic [REG_IDX_W-1:0] id_rs2;
  logic                 id_rs1_used;
  logic                 id_rs2_used;
  logic [REG_IDX_W-1:0] ex_reg_dst;
  logic                 ex_reg_wr;
  logic                 ex_is_load;
  logic                 ex_redirect;
  logic                 mem_req;
  logic                 mem_ready;
  logic                 wb_halt;

  logic                 stall_pc;
  logic                 stall_if_id;
  logic                 stall_id_ex;
  logic                 stall_ex_mem;
  logic                 stall_mem_wb;
  logic                 flush_if_id;
  logic                 flush_id_ex;
  logic                 flush_ex_mem;
  logic                 flush_mem_wb;
  logic                 halted;
  logic                 mem_err;
  logic [31:0]          stall_cycles;

  modport master (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_reg_dst, ex_reg_wr,
           ex_is_load, ex_redirect, mem_req, mem_ready, wb_halt,
    input  stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb,
           flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb,
           halted, mem_err, stall_cycles
  );

  modport slave (
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_reg_dst, ex_reg_wr,
           ex_is_load, ex_redirect, mem_req, mem_ready, wb_halt,
    output stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb,
           flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb,
           halted, mem_err, stall_cycles
  );
endinterface

// File: rtl/hazard_detect.sv
// Load-use detector: flags an ID instruction that reads the register a load
// in EX is about to write. Purely combinational.
module hazard_detect
  import cpu_pkg::*;
#(
  parameter int R0_ZERO = 1
) (
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_rs1_used,
  input  logic                 id_rs2_used,
  input  logic [REG_IDX_W-1:0] ex_reg_dst,
  input  logic                 ex_reg_wr,
  input  logic                 ex_is_load,
  output logic                 load_use
);

  logic dst_live;
  logic src_match;

  // A hardwired-zero destination never produces a value worth waiting for.
  always_comb begin
    dst_live  = (ex_reg_dst != ZERO_REG) || (R0_ZERO == 0);
    src_match = (id_rs1_used && (id_rs1 == ex_reg_dst)) ||
                (id_rs2_used && (id_rs2 == ex_reg_dst));
    load_use  = ex_is_load && ex_reg_wr && dst_live && src_match;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Central stall/flush controller for the PC and the IF/ID, ID/EX, EX/MEM and
// MEM/WB registers. Handles data-memory waits (with timeout), EX redirects,
// load-use hazards and halt, and counts stalled cycles.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int R0_ZERO     = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  hazard_ctrl_if.slave bus
);

  localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(MEM_TIMEOUT);
  localparam logic             TO_EN  = (MEM_TIMEOUT != 0);

  hz_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_err_q, mem_err_d;
  logic [31:0]      stall_cycles_q;
  logic             load_use;
  logic             mem_stall;
  hz_ctl_t          ctl;

  hazard_detect #(.R0_ZERO(R0_ZERO)) u_detect (
    .id_rs1      (bus.id_rs1),
    .id_rs2      (bus.id_rs2),
    .id_rs1_used (bus.id_rs1_used),
    .id_rs2_used (bus.id_rs2_used),
    .ex_reg_dst  (bus.ex_reg_dst),
    .ex_reg_wr   (bus.ex_reg_wr),
    .ex_is_load  (bus.ex_is_load),
    .load_use    (load_use)
  );

  // Memory-wait condition; in MEM_WAIT it drops as soon as memory is ready.
  always_comb begin
    mem_stall = 1'b0;
    case (state_q)
      RUN:      mem_stall = bus.mem_req && !bus.mem_ready;
      MEM_WAIT: mem_stall = !bus.mem_ready;
      default:  mem_stall = 1'b0;
    endcase
  end

  // Priority mux for the stall/flush strobes; a redirect held in EX during a
  // memory wait is serviced naturally once the wait clears.
  always_comb begin
    ctl = '0;
    if (state_q == HALTED || mem_stall) begin
      ctl = HZ_GROUP_A;
    end else if (bus.ex_redirect) begin
      ctl = HZ_REDIRECT;
    end else if (load_use) begin
      ctl = HZ_LOAD_USE;
    end
    if (!rst_n) begin
      ctl = '0;
    end
  end

  // Next-state, wait counter and timeout error; halt overrides everything.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_err_d = mem_err_q;
    if (bus.wb_halt) begin
      state_d = HALTED;
      cnt_d   = '0;
    end else begin
      case (state_q)
        RUN: begin
          if (mem_stall) begin
            state_d = MEM_WAIT;
            cnt_d   = CNT_W'(1);
          end else begin
            cnt_d = '0;
          end
        end
        MEM_WAIT: begin
          if (bus.mem_ready) begin
            state_d = RUN;
            cnt_d   = '0;
          end else if (TO_EN && (cnt_q == TO_VAL)) begin
            state_d   = HALTED;
            mem_err_d = 1'b1;
            cnt_d     = '0;
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = HALTED;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, counter and sticky error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  // Saturating count of cycles in which the PC is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
    end else if (ctl.stall_pc && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_q <= stall_cycles_q + 32'd1;
    end
  end

  assign bus.stall_pc     = ctl.stall_pc;
  assign bus.stall_if_id  = ctl.stall_if_id;
  assign bus.stall_id_ex  = ctl.stall_id_ex;
  assign bus.stall_ex_mem = ctl.stall_ex_mem;
  assign bus.stall_mem_wb = ctl.stall_mem_wb;
  assign bus.flush_if_id  = ctl.flush_if_id;
  assign bus.flush_id_ex  = ctl.flush_id_ex;
  assign bus.flush_ex_mem = ctl.flush_ex_mem;
  assign bus.flush_mem_wb = ctl.flush_mem_wb;
  assign bus.halted       = (state_q == HALTED);
  assign bus.mem_err      = mem_err_q;
  assign bus.stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use, redirect priority, memory wait
// with pending redirect, timeout, halt, async reset and counter saturation.
module tb_hazard_ctrl;
  import cpu_pkg::*;

  // Strobe vector order: stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
  // stall_mem_wb, flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb.
  localparam logic [31:0] O_NONE = 32'h000;
  localparam logic [31:0] O_GA   = 32'h1E1;
  localparam logic [31:0] O_LU   = 32'h184;
  localparam logic [31:0] O_RD   = 32'h00C;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errs;

  hazard_ctrl_if hz();

  hazard_ctrl #(.MEM_TIMEOUT(4), .R0_ZERO(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] outs();
    return {23'd0, hz.stall_pc, hz.stall_if_id, hz.stall_id_ex, hz.stall_ex_mem,
            hz.stall_mem_wb, hz.flush_if_id, hz.flush_id_ex, hz.flush_ex_mem,
            hz.flush_mem_wb};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    hz.id_rs1 = 4'd0;      hz.id_rs2 = 4'd0;
    hz.id_rs1_used = 1'b0; hz.id_rs2_used = 1'b0;
    hz.ex_reg_dst = 4'd0;  hz.ex_reg_wr = 1'b0;
    hz.ex_is_load = 1'b0;  hz.ex_redirect = 1'b0;
    hz.mem_req = 1'b0;     hz.mem_ready = 1'b0;
    hz.wb_halt = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errs   = 0;
    idle();
    rst_n = 1'b0;
    hz.mem_req = 1'b1;
    #2;
    chk("rst_outs_gated", outs(), O_NONE);
    chk("rst_halted", 32'(hz.halted), 32'd0);
    chk("rst_mem_err", 32'(hz.mem_err), 32'd0);
    chk("rst_stall_cnt", hz.stall_cycles, 32'd0);
    tick();
    idle();
    rst_n = 1'b1;
    #1;
    chk("idle_outs", outs(), O_NONE);

    // load-use on rs2
    hz.ex_is_load = 1'b1; hz.ex_reg_wr = 1'b1; hz.ex_reg_dst = 4'd5;
    hz.id_rs2 = 4'd5; hz.id_rs2_used = 1'b1;
    #1 chk("lu_rs2", outs(), O_LU);
    tick();
    idle();
    #1 chk("lu_cleared", outs(), O_NONE);
    chk("lu_stall_cnt", hz.stall_cycles, 32'd1);

    // r0 destination never stalls
    hz.ex_is_load = 1'b1; hz.ex_reg_wr = 1'b1; hz.ex_reg_dst = 4'd0;
    hz.id_rs2 = 4'd0; hz.id_rs2_used = 1'b1;
    #1 chk("lu_r0", outs(), O_NONE);
    tick();
    chk("lu_r0_cnt", hz.stall_cycles, 32'd1);

    // matching rs1 but the load does not write
    idle();
    hz.ex_is_load = 1'b1; hz.ex_reg_wr = 1'b0; hz.ex_reg_dst = 4'd7;
    hz.id_rs1 = 4'd7; hz.id_rs1_used = 1'b1;
    #1 chk("lu_no_wr", outs(), O_NONE);
    hz.ex_reg_wr = 1'b1;
    #1 chk("lu_rs1", outs(), O_LU);
    tick();
    chk("lu_rs1_cnt", hz.stall_cycles, 32'd2);

    // redirect beats load-use
    hz.ex_redirect = 1'b1;
    #1 chk("rd_over_lu", outs(), O_RD);
    tick();
    chk("rd_cnt", hz.stall_cycles, 32'd2);

    // single-cycle memory access
    idle();
    hz.mem_req = 1'b1; hz.mem_ready = 1'b1;
    #1 chk("mem_1cyc", outs(), O_NONE);
    tick();
    chk("mem_1cyc_state", 32'(dut.state_q), 32'(RUN));

    // 3-cycle memory wait holding a redirect
    idle();
    hz.mem_req = 1'b1; hz.mem_ready = 1'b0; hz.ex_redirect = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("mw_grpA_%0d", i), outs(), O_GA);
      tick();
    end
    hz.mem_ready = 1'b1;
    #1 chk("mw_redirect", outs(), O_RD);
    tick();
    chk("mw_state_run", 32'(dut.state_q), 32'(RUN));
    chk("mw_stall_cnt", hz.stall_cycles, 32'd5);
    idle();
    #1 chk("mw_after", outs(), O_NONE);

    // halt pulse
    hz.wb_halt = 1'b1;
    #1 chk("halt_cycle_outs", outs(), O_NONE);
    chk("halt_cycle_halted", 32'(hz.halted), 32'd0);
    tick();
    hz.wb_halt = 1'b0;
    hz.ex_redirect = 1'b1;
    #1 chk("halted_flag", 32'(hz.halted), 32'd1);
    chk("halted_outs", outs(), O_GA);
    for (int i = 0; i < 3; i++) tick();
    chk("halted_hold", outs(), O_GA);
    chk("halted_still", 32'(hz.halted), 32'd1);
    chk("halted_cnt", hz.stall_cycles, 32'd8);

    // async reset out of HALTED
    rst_n = 1'b0;
    #1 chk("arst_halted", 32'(hz.halted), 32'd0);
    chk("arst_outs", outs(), O_NONE);
    chk("arst_cnt", hz.stall_cycles, 32'd0);
    idle();
    #1 rst_n = 1'b1;
    tick();

    // timeout: MEM_TIMEOUT=4
    hz.mem_req = 1'b1; hz.mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1 chk($sformatf("to_grpA_%0d", i), outs(), O_GA);
      chk($sformatf("to_no_err_%0d", i), 32'(hz.mem_err), 32'd0);
      tick();
    end
    chk("to_mem_err", 32'(hz.mem_err), 32'd1);
    chk("to_halted", 32'(hz.halted), 32'd1);
    chk("to_outs", outs(), O_GA);
    rst_n = 1'b0;
    #1 chk("to_rst_err", 32'(hz.mem_err), 32'd0);
    chk("to_rst_halted", 32'(hz.halted), 32'd0);
    chk("to_rst_outs", outs(), O_NONE);
    chk("to_rst_state", 32'(dut.state_q), 32'(RUN));
    idle();
    #1 rst_n = 1'b1;
    tick();

    // saturation of stall_cycles under a held load-use
    hz.ex_is_load = 1'b1; hz.ex_reg_wr = 1'b1; hz.ex_reg_dst = 4'd3;
    hz.id_rs1 = 4'd3; hz.id_rs1_used = 1'b1;
    force dut.stall_cycles_q = 32'hFFFF_FFFD;
    #1 release dut.stall_cycles_q;
    chk("sat_lu", outs(), O_LU);
    tick();
    chk("sat_step", hz.stall_cycles, 32'hFFFF_FFFE);
    tick();
    chk("sat_max", hz.stall_cycles, 32'hFFFF_FFFF);
    tick();
    tick();
    chk("sat_stick", hz.stall_cycles, 32'hFFFF_FFFF);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
